fft_frame_in: RTL and testbench

FFT_FRAME_IN -- requirements
Module: fft_frame_in

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_frame_in.sv | 124 ++++++++++++
 tb/tb_fft_frame_in.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT input framing path.
package fft_pkg;

  localparam int CW     = 32;  // complex sample width {re, im}
  localparam int N      = 8;   // FFT size / frame length
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  // 3-bit index reversal used for decimation-in-time input ordering.
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_in.sv
// Collects 8 complex samples into a frame and presents them in parallel to the
// 8-point FFT. Seven samples are buffered; the eighth is folded straight into
// the output load so a frame completes on its last accept with 1-cycle latency.
module fft_frame_in
  import fft_pkg::*;
#(
  parameter int BITREV = 0
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [CW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [CW-1:0] x0,
  output logic [CW-1:0] x1,
  output logic [CW-1:0] x2,
  output logic [CW-1:0] x3,
  output logic [CW-1:0] x4,
  output logic [CW-1:0] x5,
  output logic [CW-1:0] x6,
  output logic [CW-1:0] x7,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic          drop,
  output logic [7:0]    drop_cnt
);

  logic [2:0]    cnt_q, cnt_d;
  logic [CW-1:0] buf_q [N-1];
  logic [CW-1:0] buf_d [N-1];
  logic [CW-1:0] x_q   [N];
  logic [CW-1:0] x_d   [N];
  logic          out_full_q, out_full_d;
  logic          drop_q, drop_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          accept;
  logic          take;
  logic [CW-1:0] frame [N];  // natural-order frame if this accept completes it
  logic [CW-1:0] perm  [N];  // frame routed to its output slot

  // Only a completing accept can be blocked: the buffer can keep filling
  // while a frame waits, but the eighth sample needs the output registers.
  assign in_ready    = !((cnt_q == 3'd7) && out_full_q && !frame_ready);
  assign accept      = in_valid && in_ready;
  assign take        = out_full_q && frame_ready;
  assign frame_valid = out_full_q;
  assign drop        = drop_q;
  assign drop_cnt    = drop_cnt_q;

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign x4 = x_q[4];
  assign x5 = x_q[5];
  assign x6 = x_q[6];
  assign x7 = x_q[7];

  // Frame assembly and slot permutation are pure wiring fixed at elaboration.
  for (genvar k = 0; k < N - 1; k++) begin : g_frame
    assign frame[k] = buf_q[k];
  end
  assign frame[N-1] = in_data;

  for (genvar k = 0; k < N; k++) begin : g_perm
    localparam logic [2:0] SLOT = (BITREV != 0) ? bitrev3(3'(k)) : 3'(k);
    assign perm[SLOT] = frame[k];
  end

  // Next-state: fill, abort on SOF mid-frame, completion and downstream take.
  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    x_d        = x_q;
    out_full_d = out_full_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (take) begin
      out_full_d = 1'b0;
    end

    if (accept) begin
      if (in_sof && (cnt_q != 3'd0)) begin
        // SOF wins over completion, even at cnt==7.
        buf_d[0] = in_data;
        cnt_d    = 3'd1;
        drop_d   = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else if (cnt_q == 3'd7) begin
        x_d        = perm;
        cnt_d      = 3'd0;
        out_full_d = 1'b1;
      end else begin
        buf_d[cnt_q] = in_data;
        cnt_d        = cnt_q + 3'd1;
      end
    end
  end

  // State registers; reset clears everything including the data path.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      out_full_q <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
      for (int i = 0; i < N - 1; i++) buf_q[i] <= '0;
      for (int i = 0; i < N; i++)     x_q[i]   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      out_full_q <= out_full_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      buf_q      <= buf_d;
      x_q        <= x_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_in.sv
// Bench for fft_frame_in: one natural-order and one bit-reversed instance share
// stimulus; a frame-level reference model feeds a scoreboard of whole frames.
module tb_fft_frame_in;

  logic        ck = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        frame_ready = 1'b1;

  logic        a_ready, a_fv, a_drop;
  logic [7:0]  a_dcnt;
  logic [31:0] ax [8];
  logic        b_ready, b_fv, b_drop;
  logic [7:0]  b_dcnt;
  logic [31:0] bx [8];

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  fft_frame_in #(.BITREV(0)) dut_a (
    .ck(ck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(a_ready),
    .x0(ax[0]), .x1(ax[1]), .x2(ax[2]), .x3(ax[3]),
    .x4(ax[4]), .x5(ax[5]), .x6(ax[6]), .x7(ax[7]),
    .frame_valid(a_fv), .frame_ready(frame_ready), .drop(a_drop), .drop_cnt(a_dcnt)
  );

  fft_frame_in #(.BITREV(1)) dut_b (
    .ck(ck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(b_ready),
    .x0(bx[0]), .x1(bx[1]), .x2(bx[2]), .x3(bx[3]),
    .x4(bx[4]), .x5(bx[5]), .x6(bx[6]), .x7(bx[7]),
    .frame_valid(b_fv), .frame_ready(frame_ready), .drop(b_drop), .drop_cnt(b_dcnt)
  );

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just an ordered list of 8 accepted samples.
  logic [31:0]  part [$];      // samples of the frame being collected
  logic [255:0] exp_q [$];     // completed frames awaiting take (natural order)
  logic         exp_drop = 1'b0;
  int           exp_dcnt = 0;
  logic         m_full, m_ready;
  logic [255:0] f;

  // Model and monitor: inputs are stable at the falling edge, so the
  // handshake seen here is exactly what the next rising edge acts on.
  always @(negedge ck) begin
    if (!rst_n) begin
      for (int s = 0; s < 8; s++) begin
        chk($sformatf("rst_xa%0d", s), ax[s], 32'd0);
        chk($sformatf("rst_xb%0d", s), bx[s], 32'd0);
      end
      chk("rst_frame_valid", {31'd0, a_fv}, 32'd0);
      chk("rst_in_ready", {31'd0, a_ready}, 32'd1);
      chk("rst_drop", {31'd0, a_drop}, 32'd0);
      chk("rst_drop_cnt", {24'd0, a_dcnt}, 32'd0);
      part.delete();
      exp_q.delete();
      exp_drop = 1'b0;
      exp_dcnt = 0;
    end else begin
      m_full  = (exp_q.size() != 0);
      m_ready = !((part.size() == 7) && m_full && !frame_ready);
      chk("in_ready", {31'd0, a_ready}, {31'd0, m_ready});
      chk("in_ready_b", {31'd0, b_ready}, {31'd0, m_ready});
      chk("frame_valid", {31'd0, a_fv}, {31'd0, m_full});
      chk("frame_valid_b", {31'd0, b_fv}, {31'd0, m_full});
      chk("drop", {31'd0, a_drop}, {31'd0, exp_drop});
      chk("drop_cnt", {24'd0, a_dcnt}, 32'(exp_dcnt));
      chk("drop_cnt_b", {24'd0, b_dcnt}, 32'(exp_dcnt));

      if (m_full && frame_ready) begin
        f = exp_q.pop_front();
        for (int s = 0; s < 8; s++) begin
          chk($sformatf("frame_x%0d", s), ax[s], f[s*32 +: 32]);
          chk($sformatf("frame_rev_x%0d", s), bx[s], f[rev3(s)*32 +: 32]);
        end
      end

      exp_drop = 1'b0;
      if (in_valid && m_ready) begin
        if (in_sof && part.size() != 0) begin
          part.delete();
          exp_drop = 1'b1;
          if (exp_dcnt < 255) exp_dcnt++;
        end
        part.push_back(in_data);
        if (part.size() == 8) begin
          for (int k = 0; k < 8; k++) f[k*32 +: 32] = part[k];
          exp_q.push_back(f);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic sof);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge ck);
      if (a_ready) ok = 1'b1;
    end
    if (!ok) begin
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_300");
      $fatal(1);
    end
    @(posedge ck);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge ck);
    #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #5 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #7 rst_n = 1'b1;
    idle(1);

    // Ascending real parts, one frame, downstream always ready.
    frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(32'(k) << 16, k == 0);
    idle(3);

    // Backpressure: 15 samples with downstream stalled, then release.
    frame_ready = 1'b0;
    for (int k = 0; k < 15; k++) send(32'h0001_0000 * 32'(k + 1) + 32'(k), (k % 8) == 0);
    in_valid = 1'b1;
    in_data  = 32'h00AB_CDEF;
    in_sof   = 1'b0;
    idle(4);
    frame_ready = 1'b1;
    send(32'h00AB_CDEF, 1'b0);
    idle(3);

    // Abort after 5 samples, restart with a marked sample.
    for (int k = 0; k < 5; k++) send($urandom, k == 0);
    send(32'h0800_0000, 1'b1);
    for (int k = 0; k < 7; k++) send($urandom, 1'b0);
    idle(3);

    // SOF arriving as the eighth sample must abort, not complete.
    for (int k = 0; k < 7; k++) send($urandom, k == 0);
    send(32'h1234_5678, 1'b1);
    for (int k = 0; k < 7; k++) send($urandom, 1'b0);
    idle(2);

    // Enough aborted frames to saturate the drop counter.
    send($urandom, 1'b1);
    for (int i = 0; i < 258; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send($urandom, 1'b0);
      send($urandom, 1'b1);
    end
    idle(2);

    // Reset pulse mid-frame, then a clean frame.
    for (int k = 0; k < 3; k++) send($urandom, 1'b0);
    pulse_reset();
    idle(1);
    for (int k = 0; k < 8; k++) send(32'h0100_0000 + 32'(k), k == 0);
    idle(2);

    // Random traffic with random backpressure and occasional SOF.
    for (int c = 0; c < 2000; c++) begin
      @(posedge ck);
      #1;
      frame_ready = ($urandom % 4) != 0;
      in_valid    = ($urandom % 3) != 0;
      in_sof      = ($urandom % 12) == 0;
      in_data     = $urandom;
    end
    in_valid = 1'b0;
    frame_ready = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
